// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and WRAP encoding constants.
//
// The conversion functions work on 32-bit values, which is the widest
// counter supported. Narrower callers zero-extend their operand and take
// the low bits of the result. Zero upper bits do not disturb the low bits
// in either direction of conversion.
package gray_pkg;

    localparam int MAX_WIDTH = 32;

    // Encoding of the gray_counter WRAP parameter.
    localparam int WRAP_SAT  = 0;  // hold at the terminal count
    localparam int WRAP_ROLL = 1;  // roll over at the terminal count

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down: b[i] = g[MSB] ^ ... ^ g[i].
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// binary_to_gray: combinational binary-to-Gray converter.
//
// Ports:
//   bin   in   WIDTH  binary value
//   gray  out  WIDTH  Gray code of bin
module binary_to_gray
    import gray_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin2gray(MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with a registered Gray-code output.
//
// Parameters:
//   WIDTH      counter width, 2..32
//   WRAP       WRAP_ROLL (1) rolls over at terminal count, WRAP_SAT (0) holds
//   RESET_VAL  binary value restored by rst_n and clr
//
// Ports:
//   clk           in   1      clock, rising edge
//   rst_n         in   1      asynchronous reset, active low
//   clr           in   1      synchronous clear to RESET_VAL (highest priority)
//   load          in   1      synchronous load of load_val
//   load_is_gray  in   1      1 = load_val is Gray-coded, 0 = binary
//   load_val      in   WIDTH  value to load
//   en            in   1      count enable (lowest priority)
//   up_dn         in   1      1 = count up, 0 = count down
//   bin_out       out  WIDTH  registered binary count
//   gray_out      out  WIDTH  registered Gray code of bin_out
//   tc            out  1      terminal count for the current up_dn direction
//   wrap_pulse    out  1      registered, high for the one cycle after a wrap
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int WRAP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             wrap_pulse
);

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(RST_BIN)));
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    // Terminal count tracks the live up_dn so a direction change is seen
    // on the same edge it is sampled.
    assign tc = up_dn ? (bin_r == '1) : (bin_r == '0);

    always_comb begin
        bin_next  = bin_r;
        wrap_next = 1'b0;
        if (clr) begin
            bin_next = RST_BIN;
        end else if (load) begin
            if (load_is_gray) begin
                bin_next = WIDTH'(gray2bin(MAX_WIDTH'(load_val)));
            end else begin
                bin_next = load_val;
            end
        end else if (en) begin
            if (tc) begin
                // In saturate mode the count simply holds at the boundary.
                if (WRAP == WRAP_ROLL) begin
                    bin_next  = up_dn ? '0 : '1;
                    wrap_next = 1'b1;
                end
            end else begin
                bin_next = up_dn ? (bin_r + ONE) : (bin_r - ONE);
            end
        end
    end

    // Gray code is formed from the next-state binary and registered, so
    // gray_out has no combinational path from inputs and stays in step
    // with bin_out.
    binary_to_gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin  (bin_next),
        .gray (gray_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r  <= RST_BIN;
            gray_r <= RST_GRAY;
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= bin_next;
            gray_r <= gray_next;
            wrap_r <= wrap_next;
        end
    end

    assign bin_out    = bin_r;
    assign gray_out   = gray_r;
    assign wrap_pulse = wrap_r;

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 5: counter and code width in bits, legal range 2..32.
REQ-002 SHALL have parameter WRAP, default 1: 1 = wrap at terminal count, 0 = saturate at terminal count.
REQ-003 SHALL have parameter RESET_VAL, default 0: binary value loaded on reset and on clr.
REQ-004 SHALL have port clk  input  1  -- the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  -- reset, asynchronous, active-low.
REQ-006 SHALL have port clr  input  1  -- synchronous clear to RESET_VAL.
REQ-007 SHALL have port load  input  1  -- synchronous load of load_val.
REQ-008 SHALL have port load_is_gray  input  1  -- 1 = load_val is Gray-coded, 0 = binary.
REQ-009 SHALL have port load_val  input  WIDTH  -- value to load.
REQ-010 SHALL have port en  input  1  -- count enable.
REQ-011 SHALL have port up_dn  input  1  -- 1 = count up, 0 = count down.
REQ-012 SHALL have port bin_out  output  WIDTH  -- registered binary count.
REQ-013 SHALL have port gray_out  output  WIDTH  -- registered Gray code of bin_out.
REQ-014 SHALL have port tc  output  1  -- terminal count for the current direction.
REQ-015 SHALL have port wrap_pulse  output  1  -- one-cycle flag, registered, marking a wrap.

Function
REQ-016 SHALL apply per-edge priority: clr, then load, then en; with none asserted, hold state.
REQ-017 SHALL, on load with load_is_gray=0, set bin_out=load_val.
REQ-018 SHALL, on load with load_is_gray=1, set bin_out=gray2bin(load_val), the prefix XOR from the MSB down.
REQ-019 SHALL, on en with up_dn=1, set bin_out=bin_out+1 modulo 2^WIDTH.
REQ-020 SHALL, on en with up_dn=0, set bin_out=bin_out-1 modulo 2^WIDTH.
REQ-021 SHALL keep gray_out == bin_out ^ (bin_out>>1) at all times.
REQ-022 SHALL register gray_out from the next-state binary value.
REQ-023 SHALL update bin_out and gray_out on the same edge as each other.
REQ-024 SHALL have no combinational path from any input to gray_out.
REQ-025 SHALL make every result visible one edge after the command edge (latency 1).
REQ-026 SHALL change exactly one bit of gray_out on every count step; load and clr may change any number of bits.
REQ-027 SHALL drive tc combinationally as (up_dn & bin_out==2^WIDTH-1) | (~up_dn & bin_out==0).
REQ-028 SHALL, when WRAP=1 and en is applied while tc=1, wrap bin_out (max->0 up, 0->max down).
REQ-029 SHALL, in that WRAP=1 case, assert wrap_pulse for exactly the following cycle.
REQ-030 SHALL, when WRAP=0 and en is applied while tc=1, hold bin_out and keep wrap_pulse=0.
REQ-031 SHALL deassert wrap_pulse in every cycle not covered by REQ-029, including a cycle where clr or load overrides en.
REQ-032 SHALL make a direction change take effect on the same edge it is sampled; there is no turnaround cycle.

Reset
REQ-033 SHALL, while rst_n=0 and without waiting for a clock edge, force bin_out=RESET_VAL, gray_out=bin2gray(RESET_VAL) and wrap_pulse=0.
REQ-034 SHALL, on reset asserted mid-count, abandon the count immediately.
REQ-035 SHALL resume counting from RESET_VAL at the first edge after rst_n deassertion.
REQ-036 SHALL have tc follow REQ-027 from the reset state.

Structure
REQ-037 SHALL take bin2gray/gray2bin functions and the WRAP encoding constants from shared package gray_pkg.
REQ-038 SHALL instantiate existing module binary_to_gray (parameter WIDTH) once, on the next-state binary value, feeding the gray_out register.
REQ-039 SHALL be a single always_ff state block plus combinational next-state logic; no other sub-modules.

Verification (WIDTH=5)
REQ-040 SHALL cover reset: rst_n=0 mid-count at bin 13 -> bin_out=0, gray_out=00000, wrap_pulse=0 before the next edge.
REQ-041 SHALL cover up-count: en=1, up_dn=1 for 32 edges from 0 -> gray 00000,00001,00011,00010,...; Hamming distance 1 per step; at bin 31 gray_out=10000 and tc=1; the next edge gives bin 0 with wrap_pulse=1 for exactly one cycle.
REQ-042 SHALL cover loads: load_val=10110 with load_is_gray=0 -> bin_out=22, gray_out=11101; load_val=11101 with load_is_gray=1 -> bin_out=22.
REQ-043 SHALL cover down-count at the boundary: from 0 with WRAP=1 -> bin 31, gray 10000, wrap_pulse=1; with WRAP=0 -> stays 0, tc=1, wrap_pulse=0.
REQ-044 SHALL cover priority: clr=1, load=1 (val 7), en=1 at bin 31 up -> bin_out=0, wrap_pulse=0; then load=1 and en=1 -> bin_out=7.
REQ-045 SHALL cover random traffic: 1000 cycles of random en/up_dn/load/clr checked against a reference model, with REQ-021 and REQ-026 checked every cycle.
